// File: rtl/nes_debugger_command_parser.sv
// Serial command decoder for the NES debugger: turns framed rx bytes into single-cycle
// value-port accesses and streams acknowledge / read-data bytes back to the transmitter.
module nes_debugger_command_parser #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_values_ena,
  output logic        o_values_wea,
  output logic [15:0] o_values_id,
  output logic [15:0] o_values_data,
  input  logic [15:0] i_values_data,
  output logic        o_overrun
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TO_ONE  = TW'(1);

  localparam logic [7:0] OP_PING   = 8'h00;
  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] RSP_PING  = 8'h4E;
  localparam logic [7:0] RSP_WRITE = 8'h01;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ARGS = 2'd1,
    S_EXEC = 2'd2,
    S_TX   = 2'd3
  } state_t;

  state_t        r_state, w_state_next;
  logic [7:0]    r_opcode, w_opcode_next;
  logic [2:0]    r_arg_cnt, w_arg_cnt_next;
  logic [31:0]   r_args, w_args_next;
  logic [TW-1:0] r_to_cnt, w_to_cnt_next;
  logic [15:0]   r_resp, w_resp_next;
  logic [1:0]    r_tx_cnt, w_tx_cnt_next;
  logic          r_tx_valid, w_tx_valid_next;
  logic [7:0]    r_tx_data, w_tx_data_next;
  logic          r_values_ena, w_values_ena_next;
  logic          r_values_wea, w_values_wea_next;
  logic [15:0]   r_values_id, w_values_id_next;
  logic [15:0]   r_values_data, w_values_data_next;
  logic          r_overrun, w_overrun_next;
  logic          w_tx_accept;
  logic          w_is_write;
  logic          w_is_read;

  assign w_tx_accept = r_tx_valid & i_tx_ready;
  assign w_is_write  = (r_opcode == OP_WRITE);
  assign w_is_read   = (r_opcode == OP_READ);

  // Next-state and next-output logic; every output is registered from these values.
  always_comb begin
    w_state_next       = r_state;
    w_opcode_next      = r_opcode;
    w_arg_cnt_next     = r_arg_cnt;
    w_args_next        = r_args;
    w_to_cnt_next      = r_to_cnt;
    w_resp_next        = r_resp;
    w_tx_cnt_next      = r_tx_cnt;
    w_tx_valid_next    = r_tx_valid;
    w_tx_data_next     = r_tx_data;
    w_values_ena_next  = 1'b0;
    w_values_wea_next  = 1'b0;
    w_values_id_next   = r_values_id;
    w_values_data_next = r_values_data;
    w_overrun_next     = r_overrun;

    case (r_state)
      S_IDLE: begin
        w_to_cnt_next = {TW{1'b0}};
        if (i_rx_valid) begin
          w_opcode_next = i_rx_data;
          case (i_rx_data)
            OP_WRITE: begin
              w_arg_cnt_next = 3'd4;
              w_state_next   = S_ARGS;
            end
            OP_READ: begin
              w_arg_cnt_next = 3'd2;
              w_state_next   = S_ARGS;
            end
            OP_PING: begin
              w_resp_next     = {RSP_PING, 8'h00};
              w_tx_valid_next = 1'b1;
              w_tx_data_next  = RSP_PING;
              w_tx_cnt_next   = 2'd1;
              w_state_next    = S_TX;
            end
            default: begin
              w_resp_next     = {RSP_ERR, 8'h00};
              w_tx_valid_next = 1'b1;
              w_tx_data_next  = RSP_ERR;
              w_tx_cnt_next   = 2'd1;
              w_state_next    = S_TX;
            end
          endcase
        end else begin
          w_opcode_next = r_opcode;
        end
      end

      S_ARGS: begin
        // A byte arriving on the timeout cycle wins: it is consumed and the counter restarts.
        if (i_rx_valid) begin
          w_args_next    = {r_args[23:0], i_rx_data};
          w_arg_cnt_next = r_arg_cnt - 3'd1;
          w_to_cnt_next  = {TW{1'b0}};
          if (r_arg_cnt == 3'd1) begin
            w_state_next      = S_EXEC;
            w_values_ena_next = 1'b1;
            w_values_wea_next = w_is_write;
            if (w_is_write) begin
              w_values_id_next   = w_args_next[31:16];
              w_values_data_next = w_args_next[15:0];
            end else begin
              w_values_id_next   = w_args_next[15:0];
            end
          end else begin
            w_state_next = S_ARGS;
          end
        end else if (r_to_cnt == TO_LAST) begin
          w_to_cnt_next  = {TW{1'b0}};
          w_arg_cnt_next = 3'd0;
          w_state_next   = S_IDLE;
        end else begin
          w_to_cnt_next = r_to_cnt + TO_ONE;
        end
      end

      S_EXEC: begin
        if (w_is_read) begin
          w_resp_next    = i_values_data;
          w_tx_data_next = i_values_data[15:8];
          w_tx_cnt_next  = 2'd2;
        end else begin
          w_resp_next    = {RSP_WRITE, 8'h00};
          w_tx_data_next = RSP_WRITE;
          w_tx_cnt_next  = 2'd1;
        end
        w_tx_valid_next = 1'b1;
        w_state_next    = S_TX;
        if (i_rx_valid) begin
          w_overrun_next = 1'b1;
        end else begin
          w_overrun_next = r_overrun;
        end
      end

      S_TX: begin
        if (w_tx_accept) begin
          if (r_tx_cnt == 2'd1) begin
            w_tx_valid_next = 1'b0;
            w_tx_cnt_next   = 2'd0;
            w_state_next    = S_IDLE;
          end else begin
            w_tx_cnt_next  = r_tx_cnt - 2'd1;
            w_tx_data_next = r_resp[7:0];
          end
        end else begin
          w_tx_cnt_next = r_tx_cnt;
        end
        if (i_rx_valid) begin
          w_overrun_next = 1'b1;
        end else begin
          w_overrun_next = r_overrun;
        end
      end

      default: begin
        w_state_next    = S_IDLE;
        w_tx_valid_next = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state       <= S_IDLE;
      r_opcode      <= 8'h00;
      r_arg_cnt     <= 3'd0;
      r_args        <= 32'h0000_0000;
      r_to_cnt      <= {TW{1'b0}};
      r_resp        <= 16'h0000;
      r_tx_cnt      <= 2'd0;
      r_tx_valid    <= 1'b0;
      r_tx_data     <= 8'h00;
      r_values_ena  <= 1'b0;
      r_values_wea  <= 1'b0;
      r_values_id   <= 16'h0000;
      r_values_data <= 16'h0000;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_opcode      <= w_opcode_next;
      r_arg_cnt     <= w_arg_cnt_next;
      r_args        <= w_args_next;
      r_to_cnt      <= w_to_cnt_next;
      r_resp        <= w_resp_next;
      r_tx_cnt      <= w_tx_cnt_next;
      r_tx_valid    <= w_tx_valid_next;
      r_tx_data     <= w_tx_data_next;
      r_values_ena  <= w_values_ena_next;
      r_values_wea  <= w_values_wea_next;
      r_values_id   <= w_values_id_next;
      r_values_data <= w_values_data_next;
      r_overrun     <= w_overrun_next;
    end
  end

  assign o_tx_valid    = r_tx_valid;
  assign o_tx_data     = r_tx_data;
  assign o_values_ena  = r_values_ena;
  assign o_values_wea  = r_values_wea;
  assign o_values_id   = r_values_id;
  assign o_values_data = r_values_data;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_nes_debugger_command_parser.sv
// Directed bench for nes_debugger_command_parser: PING, WRITE, READ with backpressure,
// unknown opcode with overrun, timeout and its boundary, and reset mid-command.
module tb_nes_debugger_command_parser;

  logic        clk;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic        v_ena;
  logic        v_wea;
  logic [15:0] v_id;
  logic [15:0] v_wdata;
  logic [15:0] v_rdata;
  logic        overrun;

  int n_checks;
  int n_fail;
  int ena_cnt;
  logic        last_wea;
  logic [15:0] last_id;
  logic [15:0] last_data;
  logic [7:0]  tx_q[$];
  int b_tx;
  int b_ena;

  nes_debugger_command_parser #(.TIMEOUT_CYCLES(16)) dut (
    .i_clk         (clk),
    .i_reset_n     (rst_n),
    .i_rx_valid    (rx_valid),
    .i_rx_data     (rx_data),
    .o_tx_valid    (tx_valid),
    .o_tx_data     (tx_data),
    .i_tx_ready    (tx_ready),
    .o_values_ena  (v_ena),
    .o_values_wea  (v_wea),
    .o_values_id   (v_id),
    .o_values_data (v_wdata),
    .i_values_data (v_rdata),
    .o_overrun     (overrun)
  );

  // Value block model: id 0x0002 reads 0xBEEF, everything else 0xDEAD.
  assign v_rdata = (v_id == 16'h0002) ? 16'hBEEF : 16'hDEAD;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: records access strobes and accepted tx bytes, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (v_ena) begin
      ena_cnt   = ena_cnt + 1;
      last_wea  = v_wea;
      last_id   = v_id;
      last_data = v_wdata;
    end
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one byte for exactly one rising edge.
  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    b_tx  = tx_q.size();
    b_ena = ena_cnt;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tx_valid"}, {31'd0, tx_valid}, 32'd0);
    check({tag, "_tx_data"},  {24'd0, tx_data},  32'd0);
    check({tag, "_ena"},      {31'd0, v_ena},    32'd0);
    check({tag, "_wea"},      {31'd0, v_wea},    32'd0);
    check({tag, "_id"},       {16'd0, v_id},     32'd0);
    check({tag, "_data"},     {16'd0, v_wdata},  32'd0);
    check({tag, "_overrun"},  {31'd0, overrun},  32'd0);
  endtask

  initial begin
    n_checks = 0; n_fail = 0; ena_cnt = 0;
    last_wea = 1'b0; last_id = 16'h0; last_data = 16'h0;
    rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
    idle(2);
    check_reset_vals("reset");
    rst_n = 1'b1;
    idle(2);

    // PING
    tx_ready = 1'b1;
    mark();
    send(8'h00);
    check("ping_valid", {31'd0, tx_valid}, 32'd1);
    check("ping_byte", {24'd0, tx_data}, 32'h4E);
    idle(1);
    check("ping_valid_drop", {31'd0, tx_valid}, 32'd0);
    idle(2);
    check("ping_tx_count", tx_q.size() - b_tx, 32'd1);
    check("ping_no_access", ena_cnt - b_ena, 32'd0);

    // WRITE id 0x0001 data 0x0001
    mark();
    send(8'h01); send(8'h00); send(8'h01); send(8'h00); send(8'h01);
    check("wr_ena", {31'd0, v_ena}, 32'd1);
    check("wr_wea", {31'd0, v_wea}, 32'd1);
    check("wr_id", {16'd0, v_id}, 32'h0001);
    check("wr_data", {16'd0, v_wdata}, 32'h0001);
    idle(1);
    check("wr_ena_single", {31'd0, v_ena}, 32'd0);
    check("wr_ack_valid", {31'd0, tx_valid}, 32'd1);
    check("wr_ack_byte", {24'd0, tx_data}, 32'h01);
    idle(3);
    check("wr_tx_count", tx_q.size() - b_tx, 32'd1);
    check("wr_access_count", ena_cnt - b_ena, 32'd1);

    // READ id 0x0002 with tx backpressure
    tx_ready = 1'b0;
    mark();
    send(8'h02); send(8'h00); send(8'h02);
    check("rd_ena", {31'd0, v_ena}, 32'd1);
    check("rd_wea", {31'd0, v_wea}, 32'd0);
    check("rd_id", {16'd0, v_id}, 32'h0002);
    idle(1);
    check("rd_valid", {31'd0, tx_valid}, 32'd1);
    check("rd_hi", {24'd0, tx_data}, 32'hBE);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      check("rd_hi_hold", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hBE});
    end
    tx_ready = 1'b1;
    idle(1);
    check("rd_lo", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hEF});
    idle(1);
    check("rd_valid_drop", {31'd0, tx_valid}, 32'd0);
    check("rd_tx_count", tx_q.size() - b_tx, 32'd2);
    check("rd_access_count", ena_cnt - b_ena, 32'd1);

    // Unknown opcode, then an rx byte during TX
    tx_ready = 1'b0;
    mark();
    send(8'h7F);
    check("unk_byte", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hEE});
    check("unk_no_overrun_yet", {31'd0, overrun}, 32'd0);
    send(8'h01);
    check("unk_overrun", {31'd0, overrun}, 32'd1);
    tx_ready = 1'b1;
    idle(3);
    check("unk_overrun_sticky", {31'd0, overrun}, 32'd1);
    check("unk_tx_count", tx_q.size() - b_tx, 32'd1);
    check("unk_tx_byte", {24'd0, tx_q[b_tx]}, 32'hEE);
    check("unk_no_access", ena_cnt - b_ena, 32'd0);
    mark();
    send(8'h00);
    idle(3);
    check("unk_ping_count", tx_q.size() - b_tx, 32'd1);
    check("unk_ping_byte", {24'd0, tx_q[b_tx]}, 32'h4E);

    // Timeout: 16 idle cycles in ARGS abort the command
    mark();
    send(8'h01); send(8'h00);
    idle(16);
    send(8'h00);
    idle(3);
    check("to_tx_count", tx_q.size() - b_tx, 32'd1);
    check("to_ping_byte", {24'd0, tx_q[b_tx]}, 32'h4E);
    check("to_no_access", ena_cnt - b_ena, 32'd0);

    // Timeout boundary: byte on the firing cycle keeps the command alive
    mark();
    send(8'h01); send(8'h00);
    idle(15);
    send(8'h33); send(8'h00); send(8'h05);
    check("tb_ena", {31'd0, v_ena}, 32'd1);
    check("tb_id", {16'd0, v_id}, 32'h0033);
    check("tb_data", {16'd0, v_wdata}, 32'h0005);
    idle(3);
    check("tb_access_count", ena_cnt - b_ena, 32'd1);
    check("tb_tx_count", tx_q.size() - b_tx, 32'd1);
    check("tb_ack_byte", {24'd0, tx_q[b_tx]}, 32'h01);

    // Reset during the third argument byte of a WRITE
    mark();
    send(8'h01); send(8'h00); send(8'h01);
    rx_valid = 1'b1;
    rx_data  = 8'h00;
    rst_n    = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
    check_reset_vals("midrst");
    idle(1);
    rst_n = 1'b1;
    idle(10);
    check("midrst_no_access", ena_cnt - b_ena, 32'd0);
    check("midrst_no_tx", tx_q.size() - b_tx, 32'd0);
    mark();
    send(8'h02); send(8'h00); send(8'h02);
    idle(4);
    check("post_rd_count", tx_q.size() - b_tx, 32'd2);
    check("post_rd_hi", {24'd0, tx_q[b_tx]}, 32'hBE);
    check("post_rd_lo", {24'd0, tx_q[b_tx + 1]}, 32'hEF);
    check("post_rd_access", {15'd0, last_wea, last_id}, {15'd0, 1'b0, 16'h0002});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
